ex_mdu_stage: RTL and testbench

EX-stage RV32M multiply/divide unit that sits directly downstream of the forwarding hazard logic. It selects each source operand from the ID/EX, EX/MM or MM/WB path using the hazard unit's 2-bit forward selects and latches both operands at issue. It computes MUL/MULH/MULHSU/MULHU in one registered cycle and DIV/DIVU/REM/REMU with a radix-2 restoring divider. While a divide is in progress it raises a stall request to the pipeline control.

---
 rtl/ex_mdu_stage.sv | 205 ++++++++++++++++++++
 tb/tb_ex_mdu_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ex_mdu_stage: RV32M EX-stage multiply/divide unit with forwarded       |
// | operands. Divider is built only when EX_MDU_DIV_EN is defined.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module ex_mdu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] id_ex_rs1_data_i,
  input  logic [XLEN-1:0] id_ex_rs2_data_i,
  input  logic [XLEN-1:0] ex_mm_result_i,
  input  logic [XLEN-1:0] mm_wb_result_i,
  input  logic [1:0]      forward_a_i,
  input  logic [1:0]      forward_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] op_a, op_b;
  logic            accept;
  logic            busy;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic [63:0]     mul_a, mul_b, mul_prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    case (forward_a_i)
      2'b10:   op_a = ex_mm_result_i;
      2'b01:   op_a = mm_wb_result_i;
      default: op_a = id_ex_rs1_data_i;
    endcase
    case (forward_b_i)
      2'b10:   op_b = ex_mm_result_i;
      2'b01:   op_b = mm_wb_result_i;
      default: op_b = id_ex_rs2_data_i;
    endcase
  end

  assign accept = valid_i && !busy && !flush_i;

  // Low 64 bits of the extended product are exact for every signedness mix.
  always_comb begin
    mul_a    = {{(64-XLEN){(funct3_i[1:0] != 2'b11) & op_a[XLEN-1]}}, op_a};
    mul_b    = {{(64-XLEN){!funct3_i[1] & op_b[XLEN-1]}}, op_b};
    mul_prod = mul_a * mul_b;
    mul_res  = (funct3_i[1:0] == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
  end

`ifdef EX_MDU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            want_rem_q, want_rem_d;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] quo_nxt, rem_nxt, quo_fin, rem_fin;
  logic            is_signed;
  logic [XLEN-1:0] abs_a, abs_b;

  assign busy = (state_q == DIV);

  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    if (shifted >= {1'b0, dvsr_q}) begin
      rem_nxt = XLEN'(shifted - {1'b0, dvsr_q});
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    quo_fin   = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fin   = neg_rem_q ? -rem_nxt : rem_nxt;
    is_signed = !funct3_i[0];
    abs_a     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    abs_b     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    dvsr_d         = dvsr_q;
    neg_quo_d      = neg_quo_q;
    neg_rem_d      = neg_rem_q;
    want_rem_d     = want_rem_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == DIV) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
      if (cnt_q == 5'd0) begin
        state_d        = DONE;
        result_valid_d = 1'b1;
        result_d       = want_rem_q ? rem_fin : quo_fin;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end else begin
      state_d = IDLE;
      if (accept) begin
        if (!funct3_i[2]) begin
          result_d       = mul_res;
          result_valid_d = 1'b1;
        end else if (op_b == '0) begin
          result_d       = funct3_i[1] ? op_a : '1;
          result_valid_d = 1'b1;
        end else if (is_signed && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1) begin
          result_d       = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          result_valid_d = 1'b1;
        end else begin
          state_d    = DIV;
          cnt_d      = 5'd31;
          quo_d      = abs_a;
          rem_d      = '0;
          dvsr_d     = abs_b;
          neg_quo_d  = is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
          neg_rem_d  = is_signed && op_a[XLEN-1];
          want_rem_d = funct3_i[1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      want_rem_q <= want_rem_d;
    end
  end

  assign illegal_o = 1'b0;
`else
  logic illegal_q, illegal_d;

  assign busy = 1'b0;

  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    illegal_d      = 1'b0;
    if (accept) begin
      result_valid_d = 1'b1;
      if (funct3_i[2]) begin
        result_d  = '0;
        illegal_d = 1'b1;
      end else begin
        result_d  = mul_res;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_o = illegal_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy_o         = busy;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu_stage.sv
`default_nettype none
// Directed bench for ex_mdu_stage with a result scoreboard; adapts its
// divide expectations to whether EX_MDU_DIV_EN is defined.
module tb_ex_mdu_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0, exmm = '0, mmwb = '0;
  logic [1:0]  fa = 2'b00, fb = 2'b00;
  logic        busy_o, result_valid_o, illegal_o;
  logic [31:0] result_o;

`ifdef EX_MDU_DIV_EN
  localparam int DIV_LAT  = 33;
  localparam int DIV_BUSY = 32;
`else
  localparam int DIV_LAT  = 1;
  localparam int DIV_BUSY = 0;
`endif

  logic [32:0] sb_val[$];
  string       sb_tag[$];
  int          n_cmp = 0;
  int          n_err = 0;

  ex_mdu_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .funct3_i(funct3_i),
    .id_ex_rs1_data_i(rs1), .id_ex_rs2_data_i(rs2),
    .ex_mm_result_i(exmm), .mm_wb_result_i(mmwb),
    .forward_a_i(fa), .forward_b_i(fb), .flush_i(flush_i),
    .busy_o(busy_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mul_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sbv = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint unsigned p;
    case (f3[1:0])
      2'b01:   p = longint'(sa * sbv);
      2'b10:   p = longint'(sa * longint'(ub));
      default: p = ua * ub;
    endcase
    return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa = a;
    logic signed [31:0] sbv = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
    case (f3[1:0])
      2'b00:   return sa / sbv;
      2'b01:   return a / b;
      2'b10:   return sa % sbv;
      default: return a % b;
    endcase
  endfunction

  task automatic push_val(input string tag, input logic [31:0] res, input logic ill);
    sb_tag.push_back(tag);
    sb_val.push_back({ill, res});
  endtask

  task automatic push_exp(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) push_val(tag, mul_model(f3, a, b), 1'b0);
    else begin
`ifdef EX_MDU_DIV_EN
      push_val(tag, div_model(f3, a, b), 1'b0);
`else
      push_val(tag, 32'd0, 1'b1);
`endif
    end
  endtask

  // Scoreboard: every result pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (!rst_i && (result_valid_o || illegal_o)) begin
      if (sb_val.size() == 0) begin
        chk("unexpected_result", {30'd0, illegal_o, result_valid_o}, 32'd0);
      end else begin
        string       t;
        logic [32:0] e;
        t = sb_tag.pop_front();
        e = sb_val.pop_front();
        chk({t, "_res"}, result_o, e[31:0]);
        chk({t, "_ill"}, {31'd0, illegal_o}, {31'd0, e[32]});
        chk({t, "_vld"}, {31'd0, result_valid_o}, 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i  = 1'b1;
    funct3_i = f3;
    rs1      = a;
    rs2      = b;
    fa       = 2'b00;
    fb       = 2'b00;
    step();
    valid_i  = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input int nbusy);
    int bc = 0;
    int rv_at = 0;
    push_exp(tag, f3, a, b);
    issue(f3, a, b);
    for (int k = 1; k <= 40; k++) begin
      if (busy_o) bc++;
      if (result_valid_o && rv_at == 0) rv_at = k;
      step();
    end
    chk({tag, "_lat"}, 32'(rv_at), 32'(lat));
    chk({tag, "_busy"}, 32'(bc), 32'(nbusy));
  endtask

  logic [2:0]  mf3 [7] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [31:0] ma  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                           32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] mb  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd9,
                           32'h8000_0000, 32'h8000_0000, 32'h8000_0000};

  initial begin
    int cnt;
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_vld", {31'd0, result_valid_o}, 32'd0);
    chk("rst_ill", {31'd0, illegal_o}, 32'd0);
    chk("rst_res", result_o, 32'd0);

    // Forwarded rs1 from EX/MM; later forward changes must not matter.
    push_val("fwd_mul", 32'd21, 1'b0);
    valid_i = 1'b1; funct3_i = 3'd0; rs1 = 32'd5; exmm = 32'd7; fa = 2'b10;
    rs2 = 32'd3; fb = 2'b00; mmwb = 32'd11;
    step();
    valid_i = 1'b0; exmm = 32'd100; fa = 2'b00;
    chk("fwd_vld", {31'd0, result_valid_o}, 32'd1);
    chk("fwd_busy", {31'd0, busy_o}, 32'd0);
    step();

    // Back-to-back multiplies, one result per cycle.
    for (int i = 0; i < 7; i++) begin
      push_exp($sformatf("mul%0d", i), mf3[i], ma[i], mb[i]);
      issue(mf3[i], ma[i], mb[i]);
      chk($sformatf("mul%0d_b2b_vld", i), {31'd0, result_valid_o}, 32'd1);
    end
    step();

    run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, DIV_LAT, DIV_BUSY);
    run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, DIV_LAT, DIV_BUSY);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, DIV_LAT, DIV_BUSY);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, DIV_LAT, DIV_BUSY);
    run_op("div_7_m2",   3'd4, 32'd7, 32'hFFFF_FFFE, DIV_LAT, DIV_BUSY);
    run_op("rem_7_m2",   3'd6, 32'd7, 32'hFFFF_FFFE, DIV_LAT, DIV_BUSY);
    run_op("divu_by0",   3'd5, 32'd9, 32'd0, 1, 0);
    run_op("remu_by0",   3'd7, 32'd9, 32'd0, 1, 0);
    run_op("div_by0",    3'd4, 32'hFFFF_FFFB, 32'd0, 1, 0);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);

    // MUL presented during the divide's DONE cycle.
    push_exp("b2b_div", 3'd4, 32'd100, 32'd7);
    issue(3'd4, 32'd100, 32'd7);
    for (int k = 0; k < 40 && !result_valid_o; k++) step();
    chk("b2b_div_seen", {31'd0, result_valid_o}, 32'd1);
    push_exp("b2b_mul", 3'd0, 32'd6, 32'd7);
    issue(3'd0, 32'd6, 32'd7);
    chk("b2b_mul_vld", {31'd0, result_valid_o}, 32'd1);
    step();

    // flush_i blocks acceptance on the same edge.
    valid_i = 1'b1; funct3_i = 3'd0; rs1 = 32'd3; rs2 = 32'd3; flush_i = 1'b1;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_noacc", {31'd0, result_valid_o}, 32'd0);

    // Flush in cycle N+10 of a divide.
`ifndef EX_MDU_DIV_EN
    push_exp("flush_div", 3'd5, 32'd100, 32'd7);
`endif
    issue(3'd5, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) step();
    chk("flush_busy_pre", {31'd0, busy_o}, 32'(DIV_BUSY != 0));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_busy_post", {31'd0, busy_o}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid_o) cnt++;
      step();
    end
    chk("flush_no_result", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of a divide.
`ifndef EX_MDU_DIV_EN
    push_exp("rst_div", 3'd4, 32'd100, 32'd7);
`endif
    issue(3'd4, 32'd100, 32'd7);
    for (int k = 0; k < 5; k++) step();
    #2 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_vld", {31'd0, result_valid_o}, 32'd0);
    chk("arst_ill", {31'd0, illegal_o}, 32'd0);
    chk("arst_res", result_o, 32'd0);
    step();
    rst_i = 1'b0;
    step();
    chk("arst_busy_after", {31'd0, busy_o}, 32'd0);
    step();

    chk("sb_drained", 32'(sb_val.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
